// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and stream framing sizes.
package boot_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BITS       = 8 * HDR_BYTES;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    LOAD  = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } boot_state_e;

  function automatic logic is_loading(input boot_state_e s);
    return s inside {HDR0, HDR1, LOAD, CHK};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = the loader itself, slave = the environment (UART side and memory).
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/byte_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word_valid pulses
// for one cycle after the fourth byte of a word has been captured.
module byte_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [IDX_W-1:0] idx_reg;
  logic             word_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg        <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= byte_en && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
      if (byte_en) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // One byte lane per generate instance; the index selects which lane captures.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    logic [7:0] lane_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (byte_en && (idx_reg == IDX_W'(gi))) begin
        lane_reg <= byte_data;
      end
    end

    assign word[8*gi +: 8] = lane_reg;
  end

  assign word_valid = word_valid_reg;

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian program image into instruction memory
// and releases the core reset afterwards. Define BOOT_CHECKSUM_EN for a trailing XOR check byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.master bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e END_STATE = CHK;
`else
  localparam boot_state_e END_STATE = DONE;
`endif

  boot_state_e           state_reg;
  boot_state_e           state_next;
  logic                  active_reg;
  logic [HDR_BITS-9:0]   hdr_lo_reg;
  logic [HDR_BITS-1:0]   n_words_reg;
  logic [ADDR_WIDTH-1:0] word_cnt_reg;

  logic [HDR_BITS-1:0]   n_words_rx;
  logic                  rx_ready;
  logic                  accept;
  logic                  byte_en;
  logic                  word_valid;
  logic [31:0]           word;
  logic                  last_word;
  logic                  hdr_zero;
  logic                  hdr_too_big;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            xor_reg;
`endif

  assign n_words_rx  = {bus.rx_data, hdr_lo_reg};
  assign accept      = bus.rx_valid && rx_ready;
  assign byte_en     = accept && (state_reg == LOAD);
  assign last_word   = word_valid && ((32'(word_cnt_reg) + 32'd1) == 32'(n_words_reg));
  assign hdr_zero    = (n_words_rx == '0);
  assign hdr_too_big = (32'(n_words_rx) > 32'(MAX_WORDS));

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (byte_en),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // The byte after the final payload byte must never be taken, so the
  // final write cycle closes the stream instead of overlapping the next word.
  always_comb begin
    rx_ready = 1'b0;
    if (active_reg) begin
      case (state_reg)
        HDR0, HDR1: rx_ready = 1'b1;
        LOAD:       rx_ready = !last_word;
`ifdef BOOT_CHECKSUM_EN
        CHK:        rx_ready = 1'b1;
`endif
        default:    rx_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR0: begin
        if (accept) begin
          state_next = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          if (hdr_too_big) begin
            state_next = ERROR;
          end else if (hdr_zero) begin
            state_next = END_STATE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_word) begin
          state_next = END_STATE;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_next = (bus.rx_data == xor_reg) ? DONE : ERROR;
        end
      end
`endif
      default: state_next = state_reg;
    endcase
  end

  // active_reg keeps rx_ready/busy low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= HDR0;
      active_reg   <= 1'b0;
      hdr_lo_reg   <= '0;
      n_words_reg  <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
      if (accept && (state_reg == HDR0)) begin
        hdr_lo_reg <= bus.rx_data;
      end
      if (accept && (state_reg == HDR1)) begin
        n_words_reg <= n_words_rx;
      end
      if (word_valid) begin
        word_cnt_reg <= word_cnt_reg + 1'b1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_reg <= '0;
    end else if (byte_en) begin
      xor_reg <= xor_reg ^ bus.rx_data;
    end
  end
`endif

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = word_cnt_reg;
  assign bus.imem_wdata = word;

  assign busy     = active_reg && is_loading(state_reg);
  assign done     = (state_reg == DONE);
  assign error    = (state_reg == ERROR);
  assign core_rst = (state_reg == DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Randomised scoreboard bench for boot_loader: a program model predicts every
// memory write and the final status; a monitor checks writes as they appear.
module tb_boot_loader;

  localparam int ADDR_WIDTH = 10;
  localparam int MAX_WORDS  = 1024;

  logic clk = 1'b0;
  logic rst;
  logic core_rst;
  logic busy;
  logic done;
  logic error;

  boot_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  boot_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    int                    due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          cyc        = 0;
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write, in the predicted cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.imem_we === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          e = sb.pop_front();
          $display("write addr %0d data 0x%08h", bus.imem_addr, bus.imem_wdata);
          check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
          check("write_data", bus.imem_wdata, e.data);
          check("write_cycle", cyc, e.due);
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_imem_we", bus.imem_we, 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
  endtask

  // Reset is asserted away from any rising edge, so values must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called and returns at a falling edge. When push is set the byte completes word 'addr'.
  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit push,
                           input int addr, input logic [31:0] w);
    int gap;
    int waited;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      bus.rx_data = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waited = 0;
    while (!bus.rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("rx_ready_wait", bus.rx_ready, 1);
    if (!bus.rx_ready) begin
      bus.rx_valid = 1'b0;
      return;
    end
    if (push) begin
      sb.push_back('{addr: ADDR_WIDTH'(addr), data: w, due: cyc + 1});
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input int gap_max, input bit corrupt);
    logic [15:0] n16;
    logic [31:0] w;
    bit          exp_err;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  chk;
`endif
    n16     = 16'(n);
    exp_err = (n > MAX_WORDS);
`ifdef BOOT_CHECKSUM_EN
    chk = 8'h00;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        w   = prog[i];
        chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
    end
    if (corrupt) begin
      chk     = chk ^ 8'h01;
      exp_err = 1'b1;
    end
`endif
    $display("load N=%0d max_gap=%0d corrupt_chk=%0d", n, gap_max, corrupt);
    send_byte(n16[7:0], gap_max, 1'b0, 0, 32'h0);
    send_byte(n16[15:8], gap_max, 1'b0, 0, 32'h0);
    if (n > MAX_WORDS) begin
      check("error_after_hdr", error, 1);
      check("core_rst_after_hdr", core_rst, 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = prog[i];
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8], gap_max, (b == 3), i, w);
        end
      end
`ifdef BOOT_CHECKSUM_EN
      send_byte(chk, gap_max, 1'b0, 0, 32'h0);
`else
      if (n > 0) begin
        check("rx_ready_last_write", bus.rx_ready, 0);
        check("done_last_write", done, 0);
        check("core_rst_last_write", core_rst, 0);
        @(negedge clk);
      end
`endif
      check("done_after_load", done, 32'(!exp_err));
      check("error_after_load", error, 32'(exp_err));
      check("core_rst_after_load", core_rst, 32'(!exp_err));
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (4) begin
      check("stray_rx_ready", bus.rx_ready, 0);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    check("busy_final", busy, 0);
    check("done_final", done, 32'(!exp_err));
    check("error_final", error, 32'(exp_err));
    check("core_rst_final", core_rst, 32'(!exp_err));
    check("pending_writes", sb.size(), 0);
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) begin
      prog.push_back($urandom);
    end
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b1;

    prog.delete();
    prog.push_back(32'h00000513);
    prog.push_back(32'h00100593);
    run_load(2, 0, 1'b0);

    do_reset();
    prog.delete();
    run_load(0, 0, 1'b0);

    do_reset();
    run_load(1025, 0, 1'b0);

    do_reset();
    random_prog(3);
    run_load(3, 3, 1'b0);

    // Abort a load after two payload bytes, then load a single word from scratch.
    do_reset();
    $display("load N=1 interrupted after 2 payload bytes");
    send_byte(8'h01, 0, 1'b0, 0, 32'h0);
    send_byte(8'h00, 0, 1'b0, 0, 32'h0);
    send_byte(8'hAB, 0, 1'b0, 0, 32'h0);
    send_byte(8'hCD, 0, 1'b0, 0, 32'h0);
    do_reset();
    prog.delete();
    prog.push_back(32'h00000013);
    run_load(1, 0, 1'b0);

    do_reset();
    random_prog(MAX_WORDS);
    run_load(MAX_WORDS, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      do_reset();
      n = ($urandom_range(4, 0) == 0) ? int'($urandom_range(65535, 1025))
                                      : int'($urandom_range(6, 0));
      if (n <= MAX_WORDS) begin
        random_prog(n);
      end
      run_load(n, int'($urandom_range(3, 0)), 1'b0);
    end

`ifdef BOOT_CHECKSUM_EN
    do_reset();
    prog.delete();
    prog.push_back(32'h00000513);
    run_load(1, 0, 1'b0);
    do_reset();
    run_load(1, 0, 1'b1);
    do_reset();
    prog.delete();
    run_load(0, 1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
